// File: rtl/cnnip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnnip_pkg
//  Purpose  : Shared types and width defaults for the CNN IP blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package cnnip_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 16;

    localparam logic MEM_SEL_INPUT  = 1'b0;
    localparam logic MEM_SEL_WEIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/cnnip_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cnnip_loader
//  Purpose  : Streams host words into the input or weight memory at
//             consecutive addresses and reports completion / length errors.
//  Revision : 1.0 - initial release
// ============================================================================
module cnnip_loader
    import cnnip_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk_a,
    input  logic                arstz_aq,
    input  logic                LOAD_START,
    input  logic                LOAD_SEL,
    input  logic [ADDR_W-1:0]   LOAD_BASE,
    input  logic [LEN_W-1:0]    LOAD_LEN,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                s_ready,
    output logic                to_input_mem_en,
    output logic [DATA_W/8-1:0] to_input_mem_we,
    output logic [ADDR_W-1:0]   to_input_mem_addr,
    output logic [DATA_W-1:0]   to_input_mem_din,
    output logic                to_weight_mem_en,
    output logic [DATA_W/8-1:0] to_weight_mem_we,
    output logic [ADDR_W-1:0]   to_weight_mem_addr,
    output logic [DATA_W-1:0]   to_weight_mem_din,
    output logic                LOAD_BUSY,
    output logic                LOAD_DONE,
    output logic                LOAD_ERR
);

    loader_state_e       r_state;
    loader_state_e       w_next_state;

    logic                r_sel;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_err;

    logic                r_in_en;
    logic [DATA_W/8-1:0] r_in_we;
    logic [ADDR_W-1:0]   r_in_addr;
    logic [DATA_W-1:0]   r_in_din;
    logic                r_wt_en;
    logic [DATA_W/8-1:0] r_wt_we;
    logic [ADDR_W-1:0]   r_wt_addr;
    logic [DATA_W-1:0]   r_wt_din;

    logic                w_accept;
    logic                w_final;
    logic                w_len_err;
    logic [ADDR_W-1:0]   w_addr;

    assign s_ready   = (r_state == LOAD);
    assign w_accept  = s_valid && s_ready;
    assign w_final   = (r_cnt == (r_len - LEN_W'(1)));
    // Early s_last or a missing s_last on the final beat both flag an error.
    assign w_len_err = s_last ^ w_final;
    assign w_addr    = r_base + ADDR_W'(r_cnt);

    always_ff @(posedge clk_a) begin
        if (!arstz_aq) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (LOAD_START) begin
                    w_next_state = (LOAD_LEN == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (w_accept && (w_final || s_last)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_a) begin
        if (!arstz_aq) begin
            r_sel     <= MEM_SEL_INPUT;
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_in_en   <= 1'b0;
            r_in_we   <= '0;
            r_in_addr <= '0;
            r_in_din  <= '0;
            r_wt_en   <= 1'b0;
            r_wt_we   <= '0;
            r_wt_addr <= '0;
            r_wt_din  <= '0;
        end else begin
            r_in_en <= 1'b0;
            r_in_we <= '0;
            r_wt_en <= 1'b0;
            r_wt_we <= '0;
            if ((r_state == IDLE) && LOAD_START) begin
                r_sel  <= LOAD_SEL;
                r_base <= LOAD_BASE;
                r_len  <= LOAD_LEN;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end
            if (w_accept) begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (w_len_err) begin
                    r_err <= 1'b1;
                end
                if (r_sel == MEM_SEL_WEIGHT) begin
                    r_wt_en   <= 1'b1;
                    r_wt_we   <= '1;
                    r_wt_addr <= w_addr;
                    r_wt_din  <= s_data;
                end else begin
                    r_in_en   <= 1'b1;
                    r_in_we   <= '1;
                    r_in_addr <= w_addr;
                    r_in_din  <= s_data;
                end
            end
        end
    end

    assign to_input_mem_en    = r_in_en;
    assign to_input_mem_we    = r_in_we;
    assign to_input_mem_addr  = r_in_addr;
    assign to_input_mem_din   = r_in_din;
    assign to_weight_mem_en   = r_wt_en;
    assign to_weight_mem_we   = r_wt_we;
    assign to_weight_mem_addr = r_wt_addr;
    assign to_weight_mem_din  = r_wt_din;

    assign LOAD_BUSY = (r_state == LOAD) || (r_state == DRAIN);
    assign LOAD_DONE = (r_state == DONE);
    assign LOAD_ERR  = (r_state == DONE) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_cnnip_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnnip_loader
//  Purpose  : Directed self-checking bench for cnnip_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnnip_loader;

    logic        clk_a = 1'b0;
    logic        arstz_aq;
    logic        LOAD_START;
    logic        LOAD_SEL;
    logic [15:0] LOAD_BASE;
    logic [15:0] LOAD_LEN;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        to_input_mem_en;
    logic [3:0]  to_input_mem_we;
    logic [15:0] to_input_mem_addr;
    logic [31:0] to_input_mem_din;
    logic        to_weight_mem_en;
    logic [3:0]  to_weight_mem_we;
    logic [15:0] to_weight_mem_addr;
    logic [31:0] to_weight_mem_din;
    logic        LOAD_BUSY;
    logic        LOAD_DONE;
    logic        LOAD_ERR;

    cnnip_loader #(.ADDR_W(16), .DATA_W(32), .LEN_W(16)) dut (
        .clk_a              (clk_a),
        .arstz_aq           (arstz_aq),
        .LOAD_START         (LOAD_START),
        .LOAD_SEL           (LOAD_SEL),
        .LOAD_BASE          (LOAD_BASE),
        .LOAD_LEN           (LOAD_LEN),
        .s_valid            (s_valid),
        .s_data             (s_data),
        .s_last             (s_last),
        .s_ready            (s_ready),
        .to_input_mem_en    (to_input_mem_en),
        .to_input_mem_we    (to_input_mem_we),
        .to_input_mem_addr  (to_input_mem_addr),
        .to_input_mem_din   (to_input_mem_din),
        .to_weight_mem_en   (to_weight_mem_en),
        .to_weight_mem_we   (to_weight_mem_we),
        .to_weight_mem_addr (to_weight_mem_addr),
        .to_weight_mem_din  (to_weight_mem_din),
        .LOAD_BUSY          (LOAD_BUSY),
        .LOAD_DONE          (LOAD_DONE),
        .LOAD_ERR           (LOAD_ERR)
    );

    always #5 clk_a = ~clk_a;

    typedef struct {
        bit          sel;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] din;
        int          cyc;
    } wr_t;

    wr_t  wq[$];
    int   acc_q[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic done_err = 1'b0;
    int   last_acc = 0;
    int   start_cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk_a) cyc++;

    // Write and completion monitor, sampled mid-cycle.
    always @(negedge clk_a) begin
        wr_t e;
        if (to_input_mem_en) begin
            e.sel = 1'b0; e.we = to_input_mem_we; e.addr = to_input_mem_addr;
            e.din = to_input_mem_din; e.cyc = cyc;
            wq.push_back(e);
        end
        if (to_weight_mem_en) begin
            e.sel = 1'b1; e.we = to_weight_mem_we; e.addr = to_weight_mem_addr;
            e.din = to_weight_mem_din; e.cyc = cyc;
            wq.push_back(e);
        end
        if (LOAD_DONE) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = LOAD_ERR;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_a);
            #1;
        end
    endtask

    task automatic clear_logs();
        wq.delete();
        acc_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_load(input bit sel, input logic [15:0] base, input logic [15:0] len);
        LOAD_SEL   = sel;
        LOAD_BASE  = base;
        LOAD_LEN   = len;
        LOAD_START = 1'b1;
        start_cyc  = cyc;
        tick(1);
        // Scramble the command inputs to prove they were latched.
        LOAD_START = 1'b0;
        LOAD_SEL   = ~sel;
        LOAD_BASE  = 16'h5A5A;
        LOAD_LEN   = 16'd9;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 10) begin
            tick(1);
            n++;
        end
        check("beat_ready", s_ready, 1);
        if (s_ready) begin
            acc_q.push_back(cyc);
            last_acc = cyc;
        end
        tick(1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 20) begin
            tick(1);
            n++;
        end
        tick(3);
    endtask

    task automatic verify_writes(input string tag, input bit sel, input logic [15:0] base,
                                 input int n, input logic [31:0] dbase);
        check({tag, "_nwr"}, wq.size(), n);
        for (int k = 0; k < n && k < wq.size(); k++) begin
            logic [15:0] ea;
            logic [31:0] ed;
            ea = base + 16'(k);
            ed = dbase + 32'(k);
            check({tag, "_wr"}, {wq[k].sel, wq[k].we, wq[k].addr, wq[k].din},
                  {sel, 4'hF, ea, ed});
            if (k < acc_q.size()) begin
                check({tag, "_wrlat"}, wq[k].cyc, acc_q[k] + 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        arstz_aq = 1'b0; LOAD_START = 1'b0; LOAD_SEL = 1'b0; LOAD_BASE = '0; LOAD_LEN = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        tick(3);
        check("rst_ctrl", {s_ready, LOAD_BUSY, LOAD_DONE, LOAD_ERR}, 0);
        check("rst_mem", {to_input_mem_en, to_input_mem_we, to_input_mem_addr, to_input_mem_din,
                          to_weight_mem_en, to_weight_mem_we, to_weight_mem_addr, to_weight_mem_din}, 0);
        arstz_aq = 1'b1;
        tick(2);
        check("idle_ctrl", {s_ready, LOAD_BUSY, LOAD_DONE}, 0);

        // 1: input mem, back-to-back
        clear_logs();
        start_load(1'b0, 16'h0010, 16'd4);
        check("t1_busy", LOAD_BUSY, 1);
        for (int k = 0; k < 4; k++) send_beat(32'hD100_0000 + 32'(k), k == 3);
        wait_done();
        verify_writes("t1", 1'b0, 16'h0010, 4, 32'hD100_0000);
        check("t1_done", done_cnt, 1);
        check("t1_lat", done_cyc - last_acc, 2);
        check("t1_err", done_err, 0);

        // 2: weight mem, valid 1,0,1,0,1
        clear_logs();
        start_load(1'b1, 16'h0200, 16'd3);
        for (int k = 0; k < 3; k++) begin
            send_beat(32'hB200_0000 + 32'(k), k == 2);
            if (k < 2) tick(1);
        end
        wait_done();
        verify_writes("t2", 1'b1, 16'h0200, 3, 32'hB200_0000);
        check("t2_done", done_cnt, 1);
        check("t2_err", done_err, 0);

        // 3a: early s_last on second beat
        clear_logs();
        start_load(1'b0, 16'h0100, 16'd4);
        send_beat(32'hC300_0000, 1'b0);
        send_beat(32'hC300_0001, 1'b1);
        check("t3_ready_drop", s_ready, 0);
        wait_done();
        verify_writes("t3a", 1'b0, 16'h0100, 2, 32'hC300_0000);
        check("t3a_done", done_cnt, 1);
        check("t3a_lat", done_cyc - last_acc, 2);
        check("t3a_err", done_err, 1);

        // 3b: missing s_last
        clear_logs();
        start_load(1'b1, 16'h0400, 16'd2);
        send_beat(32'hC310_0000, 1'b0);
        send_beat(32'hC310_0001, 1'b0);
        wait_done();
        verify_writes("t3b", 1'b1, 16'h0400, 2, 32'hC310_0000);
        check("t3b_err", done_err, 1);

        // 4a: address wrap 0xFFFE..0x0001
        clear_logs();
        start_load(1'b0, 16'hFFFE, 16'd4);
        for (int k = 0; k < 4; k++) send_beat(32'hE400_0000 + 32'(k), k == 3);
        wait_done();
        verify_writes("t4a", 1'b0, 16'hFFFE, 4, 32'hE400_0000);
        check("t4a_addr2", wq.size() > 2 ? wq[2].addr : 16'hDEAD, 16'h0000);
        check("t4a_err", done_err, 0);

        // 4b: zero length
        clear_logs();
        start_load(1'b1, 16'h0050, 16'd0);
        check("t4b_ready", s_ready, 0);
        wait_done();
        check("t4b_nwr", wq.size(), 0);
        check("t4b_lat", done_cyc - start_cyc, 2);
        check("t4b_err", done_err, 0);

        // 5a: start pulses during LOAD, DRAIN and DONE are ignored
        clear_logs();
        start_load(1'b0, 16'h0040, 16'd3);
        send_beat(32'hF500_0000, 1'b0);
        LOAD_START = 1'b1; LOAD_SEL = 1'b1; LOAD_BASE = 16'h0900; LOAD_LEN = 16'd1;
        send_beat(32'hF500_0001, 1'b0);
        LOAD_START = 1'b0;
        send_beat(32'hF500_0002, 1'b1);
        LOAD_START = 1'b1;
        tick(2);
        LOAD_START = 1'b0;
        tick(6);
        verify_writes("t5a", 1'b0, 16'h0040, 3, 32'hF500_0000);
        check("t5a_done", done_cnt, 1);
        check("t5a_err", done_err, 0);
        check("t5a_idle", {LOAD_BUSY, s_ready}, 0);

        // 5b: reset after 2 of 5 beats
        clear_logs();
        start_load(1'b1, 16'h0300, 16'd5);
        send_beat(32'h5B00_0000, 1'b0);
        send_beat(32'h5B00_0001, 1'b0);
        arstz_aq = 1'b0;
        tick(1);
        check("t5b_rst_ctrl", {s_ready, LOAD_BUSY, LOAD_DONE, LOAD_ERR}, 0);
        check("t5b_rst_mem", {to_input_mem_en, to_input_mem_we, to_input_mem_addr, to_input_mem_din,
                              to_weight_mem_en, to_weight_mem_we, to_weight_mem_addr, to_weight_mem_din}, 0);
        tick(1);
        arstz_aq = 1'b1;
        tick(6);
        check("t5b_nodone", done_cnt, 0);
        verify_writes("t5b", 1'b1, 16'h0300, 2, 32'h5B00_0000);

        clear_logs();
        start_load(1'b0, 16'h0077, 16'd1);
        send_beat(32'h5C00_0000, 1'b1);
        wait_done();
        verify_writes("t5c", 1'b0, 16'h0077, 1, 32'h5C00_0000);
        check("t5c_done", done_cnt, 1);
        check("t5c_err", done_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
